// File: rtl/udp_gen_pkg.sv
// Shared types and constants for the UDP/IPv4/Ethernet frame generator.
package udp_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        GAP
    } state_t;

    localparam int unsigned ETH_HDR_LEN = 14;
    localparam int unsigned IP_HDR_LEN  = 20;
    localparam int unsigned UDP_HDR_LEN = 8;
    localparam int unsigned HDR_LEN     = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
    localparam int unsigned CNT_W       = 11;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    // Full 42-byte header in wire order, first byte in the MSBs.
    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic [7:0]  ver_ihl;
        logic [7:0]  tos;
        logic [15:0] total_len;
        logic [15:0] ip_id;
        logic [15:0] flags_frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] hdr_csum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] udp_len;
        logic [15:0] udp_csum;
    } frame_hdr_t;

    localparam int unsigned HDR_W = $bits(frame_hdr_t);

endpackage

// File: rtl/ip_hdr_csum.sv
// Combinational IPv4 header checksum: ones-complement of the folded sum of ten words.
module ip_hdr_csum (
    input  logic [9:0][15:0] words,
    output logic [15:0]      csum
);

    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        sum = '0;
        for (int i = 0; i < 10; i++) begin
            sum = sum + 20'(words[i]);
        end
        fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
        fold2 = fold1[15:0] + 16'(fold1[16]);
        csum  = ~fold2;
    end

endmodule

// File: rtl/udp_tx_pkt_gen.sv
// Fixed-format UDP frame generator driving an AXI-Stream MAC TX byte port.
// Define UDP_GEN_CONT_EN to allow back-to-back frames while start is held high.
module udp_tx_pkt_gen
    import udp_gen_pkg::*;
#(
    parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_01_02_03,
    parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] SRC_IP      = 32'hC0A8_000A,
    parameter logic [31:0] DST_IP      = 32'hC0A8_0002,
    parameter logic [15:0] SRC_PORT    = 16'd5000,
    parameter logic [15:0] DST_PORT    = 16'd5001,
    parameter int unsigned PAYLOAD_LEN = 64,
    parameter int unsigned IFG_CYCLES  = 12
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic [31:0] pkt_cnt
);

    localparam logic [15:0]      TOTAL_LEN = 16'(IP_HDR_LEN + UDP_HDR_LEN + PAYLOAD_LEN);
    localparam logic [15:0]      UDP_LEN   = 16'(UDP_HDR_LEN + PAYLOAD_LEN);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] FRM_LAST  = CNT_W'(HDR_LEN + PAYLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((IFG_CYCLES == 0) ? 0 : IFG_CYCLES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             tvalid_q, tvalid_next;
    logic             tlast_q, tlast_next;
    logic [7:0]       tdata_q, byte_c;
    logic             busy_q;
    logic [15:0]      ip_id_q, csum_q, csum_c;
    logic [31:0]      pkt_cnt_q;
    logic             csum_load, frame_done;
    frame_hdr_t       hdr;
    logic [HDR_W-1:0] hdr_sh;
    logic [9:0][15:0] csum_words;

    assign csum_words = {16'h4500, TOTAL_LEN, ip_id_q, 16'h4000, {8'h40, IP_PROTO_UDP},
                         16'h0000, SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0]};

    ip_hdr_csum u_csum (
        .words(csum_words),
        .csum (csum_c)
    );

    always_comb begin
        hdr            = '0;
        hdr.dst_mac    = DST_MAC;
        hdr.src_mac    = SRC_MAC;
        hdr.ethertype  = ETHERTYPE_IPV4;
        hdr.ver_ihl    = 8'h45;
        hdr.tos        = 8'h00;
        hdr.total_len  = TOTAL_LEN;
        hdr.ip_id      = ip_id_q;
        hdr.flags_frag = 16'h4000;
        hdr.ttl        = 8'h40;
        hdr.proto      = IP_PROTO_UDP;
        hdr.hdr_csum   = csum_q;
        hdr.src_ip     = SRC_IP;
        hdr.dst_ip     = DST_IP;
        hdr.src_port   = SRC_PORT;
        hdr.dst_port   = DST_PORT;
        hdr.udp_len    = UDP_LEN;
        hdr.udp_csum   = 16'h0000;
    end

    // Byte that goes on the wire at position cnt_next.
    always_comb begin
        hdr_sh = HDR_W'(hdr) << {cnt_next[5:0], 3'b000};
        if (cnt_next < CNT_W'(HDR_LEN)) begin
            byte_c = hdr_sh[HDR_W-1 -: 8];
        end else begin
            byte_c = ip_id_q[7:0] + 8'(cnt_next - CNT_W'(HDR_LEN));
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        tvalid_next = 1'b0;
        tlast_next  = 1'b0;
        csum_load   = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = HDR;
                    cnt_next    = '0;
                    tvalid_next = 1'b1;
                    csum_load   = 1'b1;
                end
            end
            HDR, PAYLOAD: begin
                tvalid_next = 1'b1;
                tlast_next  = tlast_q;
                if (tvalid_q && m_axis_tready) begin
                    if (tlast_q) begin
                        state_next  = GAP;
                        cnt_next    = '0;
                        tvalid_next = 1'b0;
                        tlast_next  = 1'b0;
                        frame_done  = 1'b1;
                    end else begin
                        cnt_next   = cnt + CNT_W'(1);
                        tlast_next = (cnt_next == FRM_LAST);
                        if (cnt == HDR_LAST) begin
                            state_next = PAYLOAD;
                        end
                    end
                end
            end
            GAP: begin
                if (cnt >= GAP_LAST) begin
`ifdef UDP_GEN_CONT_EN
                    if (start) begin
                        state_next  = HDR;
                        cnt_next    = '0;
                        tvalid_next = 1'b1;
                        csum_load   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= 8'h00;
            busy_q    <= 1'b0;
            csum_q    <= 16'h0000;
            ip_id_q   <= 16'h0000;
            pkt_cnt_q <= 32'd0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            tvalid_q <= tvalid_next;
            tlast_q  <= tlast_next;
            tdata_q  <= tvalid_next ? byte_c : 8'h00;
            busy_q   <= (state_next != IDLE);
            if (csum_load) begin
                csum_q <= csum_c;
            end
            if (frame_done) begin
                ip_id_q   <= ip_id_q + 16'd1;
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_udp_tx_pkt_gen.sv
// Directed bench for udp_tx_pkt_gen with default parameters (PAYLOAD_LEN 64, IFG 12).
module tb_udp_tx_pkt_gen;

    localparam int FRAME = 106;

    logic        sys_clk;
    logic        sys_rst;
    logic        start;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        busy;
    logic [31:0] pkt_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] cap_q[$];
    int         cyc_q[$];
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         n_last = 0;
    int         hold_err = 0;
    int         stall_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out = '0;

    udp_tx_pkt_gen dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .start        (start),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .busy         (busy),
        .pkt_cnt      (pkt_cnt)
    );

    initial sys_clk = 1'b0;
    always #4 sys_clk = ~sys_clk;

    // Capture accepted bytes and watch that stalled outputs hold still.
    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        if (!sys_rst && prev_stall &&
            (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_out)) begin
            hold_err <= hold_err + 1;
        end
        prev_stall <= !sys_rst && m_axis_tvalid && !m_axis_tready;
        prev_out   <= {m_axis_tlast, m_axis_tdata};
        if (!sys_rst && m_axis_tvalid && !m_axis_tready) begin
            stall_cnt <= stall_cnt + 1;
        end
        if (!sys_rst && m_axis_tvalid && m_axis_tready) begin
            cap_q.push_back({m_axis_tlast, m_axis_tdata});
            cyc_q.push_back(cyc);
            if (m_axis_tlast) begin
                n_last <= n_last + 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (2) tick();
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    function automatic logic [15:0] ones_sum(input logic [7:0] b[42]);
        logic [31:0] s = 32'd0;
        for (int w = 0; w < 10; w++) begin
            s = s + 32'({b[14 + 2 * w], b[15 + 2 * w]});
        end
        while (s[31:16] != 16'd0) begin
            s = 32'(s[15:0]) + (s >> 16);
        end
        return s[15:0];
    endfunction

    task automatic build_exp(input logic [15:0] id);
        logic [7:0]  h[42];
        logic [15:0] cs;
        h = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03,
              8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h5C,
              id[15:8], id[7:0], 8'h40, 8'h00, 8'h40, 8'h11,
              8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h0A,
              8'hC0, 8'hA8, 8'h00, 8'h02, 8'h13, 8'h88,
              8'h13, 8'h89, 8'h00, 8'h48, 8'h00, 8'h00};
        cs    = ~ones_sum(h);
        h[24] = cs[15:8];
        h[25] = cs[7:0];
        exp_q.delete();
        for (int i = 0; i < 42; i++) exp_q.push_back(h[i]);
        for (int i = 0; i < 64; i++) exp_q.push_back(id[7:0] + 8'(i));
    endtask

    // Reports the index of the first wrong byte/tlast, or -1 for a clean frame.
    task automatic check_frame(input string tag, input int base, input logic [15:0] id);
        int bad = -1;
        build_exp(id);
        for (int i = 0; i < FRAME; i++) begin
            if (base + i >= cap_q.size()) begin
                if (bad < 0) bad = i;
            end else if (cap_q[base + i] !== {(i == FRAME - 1), exp_q[i]}) begin
                if (bad < 0) bad = i;
            end
        end
        chk(tag, 64'(bad), 64'(-1));
    endtask

    task automatic check_csum(input string tag, input int base);
        logic [7:0] h[42];
        for (int i = 0; i < 42; i++) begin
            h[i] = (base + i < cap_q.size()) ? cap_q[base + i][7:0] : 8'h00;
        end
        chk(tag, 64'(ones_sum(h)), 64'hFFFF);
    endtask

    function automatic logic [15:0] cap_word(input int idx);
        if (idx + 1 >= cap_q.size()) return 16'hDEAD;
        return {cap_q[idx][7:0], cap_q[idx + 1][7:0]};
    endfunction

    initial begin
        int base;
        int n;
        int lastb;

        sys_rst = 1'b1;
        start = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) tick();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        sys_rst = 1'b0;
        repeat (2) tick();
        chk("idle_no_valid", 64'(m_axis_tvalid), 64'd0);

        // Single frame with tready held high.
        cap_q.delete();
        cyc_q.delete();
        pulse_start();
        chk("first_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("first_busy", 64'(busy), 64'd1);
        chk("first_tdata", 64'(m_axis_tdata), 64'hFF);
        wait_idle("f0_done");
        chk("f0_len", 64'(cap_q.size()), 64'(FRAME));
        chk("f0_ethertype", 64'(cap_word(12)), 64'h0800);
        chk("f0_total_len", 64'(cap_word(16)), 64'h005C);
        chk("f0_csum", 64'(cap_word(24)), 64'hB934);
        chk("f0_udp_len", 64'(cap_word(38)), 64'h0048);
        check_csum("f0_csum_fold", 0);
        check_frame("f0_bytes", 0, 16'd0);
        chk("f0_pkt_cnt", 64'(pkt_cnt), 64'd1);
        chk("f0_gap_valid", 64'(m_axis_tvalid), 64'd0);

        // Same frame from reset with a randomly stalling sink.
        do_reset();
        chk("r1_pkt_cnt", 64'(pkt_cnt), 64'd0);
        cap_q.delete();
        base = stall_cnt;
        lastb = hold_err;
        pulse_start();
        n = 0;
        while (busy && n < 3000) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        m_axis_tready = 1'b1;
        chk("st_done", 64'(busy), 64'd0);
        chk("st_seen", 64'(stall_cnt != base), 64'd1);
        chk("st_hold", 64'(hold_err - lastb), 64'd0);
        check_frame("st_bytes", 0, 16'd0);
        chk("st_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Three frames: ip_id and first payload byte step 0,1,2.
        do_reset();
        cap_q.delete();
        cyc_q.delete();
`ifdef UDP_GEN_CONT_EN
        base = n_last;
        start = 1'b1;
        n = 0;
        while (n_last - base < 3 && n < 3000) begin
            tick();
            n++;
        end
        start = 1'b0;
        wait_idle("bb_done");
`else
        for (int f = 0; f < 3; f++) begin
            pulse_start();
            wait_idle("bb_done");
        end
`endif
        chk("bb_len", 64'(cap_q.size()), 64'(3 * FRAME));
        check_frame("bb_f0", 0, 16'd0);
        check_frame("bb_f1", FRAME, 16'd1);
        check_frame("bb_f2", 2 * FRAME, 16'd2);
        chk("bb_pay0", 64'(cap_q[42][7:0]), 64'h00);
        chk("bb_pay1", 64'(cap_q[FRAME + 42][7:0]), 64'h01);
        chk("bb_pay2", 64'(cap_q[2 * FRAME + 42][7:0]), 64'h02);
        chk("bb_id2", 64'(cap_word(2 * FRAME + 18)), 64'h0002);
        chk("bb_csum1", 64'(cap_word(FRAME + 24)), 64'hB933);
        chk("bb_csum2", 64'(cap_word(2 * FRAME + 24)), 64'hB932);
        chk("bb_pkt_cnt", 64'(pkt_cnt), 64'd3);
`ifdef UDP_GEN_CONT_EN
        chk("bb_gap1", 64'(cyc_q[FRAME] - cyc_q[FRAME - 1] - 1), 64'd12);
        chk("bb_gap2", 64'(cyc_q[2 * FRAME] - cyc_q[2 * FRAME - 1] - 1), 64'd12);
`endif

        // Reset while byte 30 is on the bus.
        cap_q.delete();
        base = n_last;
        pulse_start();
        repeat (30) tick();
        chk("ab_byte30", 64'(m_axis_tdata), 64'hC0);
        chk("ab_captured", 64'(cap_q.size()), 64'd30);
        chk("ab_id", 64'(cap_word(18)), 64'h0003);
        sys_rst = 1'b1;
        #1;
        chk("ab_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("ab_tlast", 64'(m_axis_tlast), 64'd0);
        chk("ab_pkt_cnt", 64'(pkt_cnt), 64'd0);
        repeat (2) tick();
        sys_rst = 1'b0;
        tick();
        chk("ab_no_tlast", 64'(n_last - base), 64'd0);
        cap_q.delete();
        pulse_start();
        wait_idle("ab_re_done");
        check_frame("ab_re_bytes", 0, 16'd0);
        chk("ab_re_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // A start pulse during PAYLOAD must not produce a second frame.
        cap_q.delete();
        pulse_start();
        repeat (60) tick();
        pulse_start();
        wait_idle("ig_done");
        repeat (40) tick();
        chk("ig_still_idle", 64'(busy), 64'd0);
        chk("ig_len", 64'(cap_q.size()), 64'(FRAME));
        check_frame("ig_bytes", 0, 16'd1);
        chk("ig_pkt_cnt", 64'(pkt_cnt), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/udp_tx_pkt_gen.md
UDP_TX_PKT_GEN -- requirements
Module: udp_tx_pkt_gen

Interface
REQ-001 SHALL have parameter SRC_MAC, default 48'h00_0A_35_01_02_03, source MAC.
REQ-002 SHALL have parameter DST_MAC, default 48'hFF_FF_FF_FF_FF_FF, destination MAC.
REQ-003 SHALL have parameter SRC_IP, default 32'hC0A8_000A (192.168.0.10), source IP.
REQ-004 SHALL have parameter DST_IP, default 32'hC0A8_0002 (192.168.0.2), destination IP.
REQ-005 SHALL have parameters SRC_PORT / DST_PORT, default 16'd5000 / 16'd5001, UDP ports.
REQ-006 SHALL have parameter PAYLOAD_LEN, default 64, payload bytes, legal range 18..1472.
REQ-007 SHALL have parameter IFG_CYCLES, default 12, idle cycles after each frame.
REQ-008 sys_clk  input  1  125 MHz MAC-side clock; all logic on rising edge.
REQ-009 sys_rst  input  1  asynchronous, active-high reset.
REQ-010 start  input  1  request one frame (sampled in IDLE only).
REQ-011 m_axis_tdata  output  8  frame byte toward MAC TX.
REQ-012 m_axis_tvalid  output  1  byte valid.
REQ-013 m_axis_tlast  output  1  final byte of frame.
REQ-014 m_axis_tready  input  1  MAC accepts byte.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 pkt_cnt  output  32  count of completed frames.

Function
REQ-017 FSM states SHALL be IDLE, HDR, PAYLOAD, GAP; IDLE->HDR on start, HDR->PAYLOAD after byte 41 accepted, PAYLOAD->GAP on the tlast handshake, GAP->IDLE after IFG_CYCLES cycles.
REQ-018 tvalid SHALL rise on the cycle after start is sampled high in IDLE; start in any other state SHALL be ignored.
REQ-019 A byte SHALL advance only on tvalid&&tready; tdata/tlast SHALL hold stable while tvalid&&!tready.
REQ-020 HDR SHALL emit 42 bytes, MSB first: DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, total_len=28+PAYLOAD_LEN, ip_id, 16'h4000, TTL 8'h40, proto 8'h11, hdr_csum, SRC_IP, DST_IP, SRC_PORT, DST_PORT, udp_len=8+PAYLOAD_LEN, UDP checksum 16'h0000.
REQ-021 hdr_csum SHALL be the 16-bit ones-complement of the ones-complement sum of the ten header words (checksum field = 0), end-around carries folded, latched on entry to HDR.
REQ-022 ip_id SHALL start at 0 and increment by 1 (wrapping 16'hFFFF->0) on each completed frame.
REQ-023 Payload byte i (0-based) SHALL be (ip_id[7:0]+i) mod 256 for the current frame's ip_id.
REQ-024 tlast SHALL be high only with payload byte PAYLOAD_LEN-1; tvalid SHALL be low in IDLE and GAP.
REQ-025 pkt_cnt SHALL increment on the tlast handshake, wrapping at 2^32.
REQ-026 Byte counter width SHALL be 11 bits, covering 42+1472.

Reset
REQ-027 sys_rst SHALL asynchronously force IDLE, tvalid=0, tlast=0, tdata=0, busy=0, pkt_cnt=0, ip_id=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no tlast; the first post-reset frame SHALL restart at byte 0 with ip_id=0.

Configuration
REQ-029 With UDP_GEN_CONT_EN defined, start held high SHALL cause GAP->HDR directly (back-to-back frames separated by exactly IFG_CYCLES idle cycles); without it, every frame SHALL require IDLE and a fresh start sample.

Structure
REQ-030 Package udp_gen_pkg SHALL hold the state enum, ETH_HDR_LEN=14, IP_HDR_LEN=20, UDP_HDR_LEN=8, ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'h11.
REQ-031 Checksum SHALL be a sub-module ip_hdr_csum (combinational fold of ten words, registered by the parent).

Verification
REQ-032 Defaults, tready=1, one start pulse -> 106 bytes, byte 12/13 = 08/00, total_len=16'h005C, tlast on byte 105, pkt_cnt=1.
REQ-033 Checksum check: bytes 24..25 equal a reference ones-complement sum of header words; reference recomputation over the full header including checksum = 16'hFFFF.
REQ-034 tready toggling 1,0,0,1 on random cycles -> byte stream identical to REQ-032, no byte duplicated or dropped.
REQ-035 Three frames back-to-back -> ip_id 0,1,2, first payload bytes 00,01,02, gap exactly 12 idle cycles (UDP_GEN_CONT_EN build).
REQ-036 sys_rst asserted at byte 30 -> tvalid low the same cycle, no tlast; next start -> frame with ip_id=0, pkt_cnt=1 afterwards.
REQ-037 start pulsed during PAYLOAD -> ignored, exactly one frame produced.
